// File: rtl/ad976_reader_pkg.sv
// ad976_reader_pkg: shared state encoding, widths and helpers
// for the AD976 read-back path.
package ad976_reader_pkg;

  localparam int CNT_W = 6;
  localparam int AVG_N = 4;
  localparam int ACC_W = 18;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t CONV    = 3'd1;
  localparam state_t WAIT_LO = 3'd2;
  localparam state_t WAIT_HI = 3'd3;
  localparam state_t READ    = 3'd4;
  localparam state_t DONE    = 3'd5;
  localparam state_t ABORT   = 3'd6;

  function automatic logic [ACC_W-1:0] sext16(
    input logic [15:0] v
  );
    return {{(ACC_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/ad976_reader_busy_sync.sv
// ad_busy_sync: two-flop synchronizer for the ADC BUSY line.
// Resets high so an idle ADC reads as not busy.
module ad_busy_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/ad976_reader.sv
// ad976_reader: AD976 convert/wait/read sequencer with sticky status.
// Define AD976_READER_AVG4_EN to average four conversions per start.
module ad976_reader
  import ad976_reader_pkg::*;
#(
  parameter int CONV_PULSE  = 2,
  parameter int RD_CYC      = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr,
  input  logic        ad_busy_n,
  input  logic [15:0] ad_data,
  output logic        ad_rc_n,
  output logic        ad_cs_n,
  output logic [15:0] rd_data,
  output logic        rdy,
  output logic        busy,
  output logic        timeout,
  output logic        overrun
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      cap_q, cap_d;
  logic [15:0]      rd_q, rd_d;
  logic             rc_n_q, cs_n_q, busy_q;
  logic             rdy_q, to_q, ov_q;
  logic             rdy_set, to_set, ov_set;
  logic             busy_s;
  logic             conv_end, read_end, wait_tmo;

  ad_busy_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ad_busy_n),
    .q_o   (busy_s)
  );

  assign conv_end = cnt_q == CNT_W'(CONV_PULSE - 1);
  assign read_end = cnt_q == CNT_W'(RD_CYC - 1);
  assign wait_tmo = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  assign ov_set   = start & busy_q;

`ifdef AD976_READER_AVG4_EN
  localparam int SMP_W = $clog2(AVG_N);

  logic [SMP_W-1:0] smp_q, smp_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic             last_smp;

  assign acc_sum  = acc_q + sext16(cap_q);
  assign last_smp = smp_q == SMP_W'(AVG_N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      acc_q <= '0;
    end else begin
      smp_q <= smp_d;
      acc_q <= acc_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rd_d    = rd_q;
    rdy_set = 1'b0;
    to_set  = 1'b0;
`ifdef AD976_READER_AVG4_EN
    smp_d   = smp_q;
    acc_d   = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (conv_end) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!busy_s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end else if (wait_tmo) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HI: begin
        if (busy_s) begin
          state_d = READ;
          cnt_d   = '0;
        end else if (wait_tmo) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        if (read_end) begin
          cap_d   = ad_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
`ifdef AD976_READER_AVG4_EN
        // Shift of the 18-bit sum floors toward minus infinity.
        if (last_smp) begin
          rd_d    = acc_sum[ACC_W-1:2];
          rdy_set = 1'b1;
          acc_d   = '0;
          smp_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = acc_sum;
          smp_d   = smp_q + 1'b1;
          cnt_d   = '0;
          state_d = CONV;
        end
`else
        rd_d    = cap_q;
        rdy_set = 1'b1;
        state_d = IDLE;
`endif
      end
      ABORT: begin
        to_set  = 1'b1;
        state_d = IDLE;
`ifdef AD976_READER_AVG4_EN
        acc_d   = '0;
        smp_d   = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      rd_q    <= '0;
      rc_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      // Decoded from next state so the pins change on the state edge.
      rc_n_q  <= state_d != CONV;
      cs_n_q  <= (state_d != CONV) && (state_d != READ);
      busy_q  <= state_d != IDLE;
      rdy_q   <= rdy_set | (rdy_q & ~clr);
      to_q    <= to_set | (to_q & ~clr);
      ov_q    <= ov_set | (ov_q & ~clr);
    end
  end

  assign ad_rc_n = rc_n_q;
  assign ad_cs_n = cs_n_q;
  assign rd_data = rd_q;
  assign rdy     = rdy_q;
  assign busy    = busy_q;
  assign timeout = to_q;
  assign overrun = ov_q;

endmodule

// File: tb/tb_ad976_reader.sv
// tb_ad976_reader: directed and random checks of ad976_reader
// against a behavioural ADC and result model.
module tb_ad976_reader;

  localparam int CONV_PULSE  = 2;
  localparam int RD_CYC      = 2;
  localparam int TIMEOUT_CYC = 32;
  localparam int LIM         = 600;
`ifdef AD976_READER_AVG4_EN
  localparam int NSMP = 4;
`else
  localparam int NSMP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        ad_busy_n = 1'b1;
  logic [15:0] ad_data = 16'h0;
  logic        ad_rc_n, ad_cs_n;
  logic [15:0] rd_data;
  logic        rdy, busy, timeout, overrun;

  int n_chk = 0;
  int n_fail = 0;

  int          tconv = 10;
  bit          stuck = 1'b0;
  logic [15:0] smp [4];
  int          smp_idx = 0;
  int          smp_base = 0;
  int          rc_pulses = 0;
  int          rc_low = 0;
  int          pulse_base = 0;
  int          low_base = 0;
  logic [15:0] last_exp;
  int          lat;
  int          lat_exp;

  always #5 clk = ~clk;

  ad976_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .ad_busy_n (ad_busy_n),
    .ad_data   (ad_data),
    .ad_rc_n   (ad_rc_n),
    .ad_cs_n   (ad_cs_n),
    .rd_data   (rd_data),
    .rdy       (rdy),
    .busy      (busy),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  // ADC: converts for tconv cycles after the R/C pulse ends.
  initial begin
    forever begin
      @(negedge ad_rc_n);
      rc_pulses++;
      @(posedge ad_rc_n);
      if (!stuck) begin
        ad_busy_n = 1'b0;
        repeat (tconv) @(posedge clk);
        #1;
        ad_data = smp[(smp_idx - smp_base) % 4];
        smp_idx++;
        ad_busy_n = 1'b1;
      end
    end
  end

  always @(posedge clk) if (ad_rc_n === 1'b0) rc_low++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic fire();
    smp_base   = smp_idx;
    pulse_base = rc_pulses;
    low_base   = rc_low;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_for(input bit want_to, output int n);
    n = 0;
    while (!(want_to ? timeout : rdy) && n < LIM) begin
      tick();
      n++;
    end
    check("wait_bound", 32'(n < LIM), 32'd1);
  endtask

  function automatic logic [15:0] ref_word();
    int s;
    s = 0;
    for (int i = 0; i < NSMP; i++) s += int'($signed(smp[i]));
    if (s < 0) s = -((-s + NSMP - 1) / NSMP);
    else s = s / NSMP;
    return 16'(s);
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_rc"},   ad_rc_n, 1);
    check({pfx, "_cs"},   ad_cs_n, 1);
    check({pfx, "_data"}, rd_data, 0);
    check({pfx, "_rdy"},  rdy, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_to"},   timeout, 0);
    check({pfx, "_ov"},   overrun, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) smp[i] = 16'h1234;
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    repeat (2) tick();

    tconv = 10;
    fire();
    wait_for(1'b0, lat);
    last_exp = ref_word();
    check("norm_data", rd_data, 16'h1234);
    check("norm_rdy", rdy, 1);
    check("norm_busy", busy, 0);
    check("norm_rc_low", rc_low - low_base, CONV_PULSE * NSMP);
    check("norm_pulses", rc_pulses - pulse_base, NSMP);
`ifndef AD976_READER_AVG4_EN
    check("norm_lat", lat, 18);
`endif

`ifdef AD976_READER_AVG4_EN
    smp[0] = 16'hFFFC; smp[1] = 16'hFFFC;
    smp[2] = 16'hFFFC; smp[3] = 16'hFFF8;
    pulse_clr();
    fire();
    wait_for(1'b0, lat);
    check("neg_data", rd_data, 16'hFFFB);
`else
    smp[0] = 16'h8001;
    pulse_clr();
    fire();
    wait_for(1'b0, lat);
    check("neg_data", rd_data, 16'h8001);
`endif
    last_exp = ref_word();
    check("neg_ref", rd_data, last_exp);

    pulse_clr();
    check("clr_rdy", rdy, 0);
    stuck = 1'b1;
    fire();
    wait_for(1'b1, lat);
    check("stk_to", timeout, 1);
    check("stk_rdy", rdy, 0);
    check("stk_data", rd_data, last_exp);
    check("stk_cs", ad_cs_n, 1);
    check("stk_lat", lat, CONV_PULSE + TIMEOUT_CYC + 1);
    tick();
    check("stk_busy", busy, 0);
    stuck = 1'b0;

    for (int i = 0; i < 4; i++) smp[i] = 16'h0F0F + 16'(i);
    fire();
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(1'b0, lat);
    last_exp = ref_word();
    check("ov_flag", overrun, 1);
    check("ov_pulses", rc_pulses - pulse_base, NSMP);
    check("ov_data", rd_data, last_exp);
    check("ov_to_kept", timeout, 1);
    pulse_clr();
    check("clr2_rdy", rdy, 0);
    check("clr2_to", timeout, 0);
    check("clr2_ov", overrun, 0);

    fire();
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    tick();
    rst_n = 1'b1;
    lat = 0;
    while (ad_busy_n !== 1'b1 && lat < LIM) begin
      tick();
      lat++;
    end
    repeat (2) tick();
    for (int i = 0; i < 4; i++) smp[i] = 16'h7FF0 - 16'(i);
    fire();
    wait_for(1'b0, lat);
    check("post_rst_data", rd_data, ref_word());
    check("post_rst_rdy", rdy, 1);

`ifndef AD976_READER_AVG4_EN
    pulse_clr();
    smp[0] = 16'hA5A5;
    lat_exp = CONV_PULSE + tconv + 2 + RD_CYC + 2;
    fire();
    repeat (lat_exp - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_done_rdy", rdy, 1);
    check("clr_done_data", rd_data, 16'hA5A5);
`endif

    for (int it = 0; it < 8; it++) begin
      tconv = int'($urandom_range(2, 15));
      for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
      pulse_clr();
      fire();
      wait_for(1'b0, lat);
      check("rnd_data", rd_data, ref_word());
      check("rnd_rdy", rdy, 1);
      check("rnd_to", timeout, 0);
`ifndef AD976_READER_AVG4_EN
      check("rnd_lat", lat, CONV_PULSE + tconv + 2 + RD_CYC + 2);
`endif
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
